// File: rtl/range_stats_unit.sv
// range_stats_unit: framed min/max/range/sum/count tracker.
// A sequence opens with go (first sample loaded unconditionally), accepts
// qualified samples while running, and closes with finish. The result
// registers update once per good sequence, with a one-cycle result_valid.
module range_stats_unit #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       data_valid,
    input  logic                       go,
    input  logic                       finish,
    output logic [WIDTH-1:0]           min_out,
    output logic [WIDTH-1:0]           max_out,
    output logic [WIDTH-1:0]           range,
    output logic [WIDTH+CNT_WIDTH-1:0] sum_out,
    output logic [CNT_WIDTH-1:0]       count_out,
    output logic                       overflow,
    output logic                       result_valid,
    output logic                       error,
    output logic                       busy
);
    localparam int SUM_WIDTH = WIDTH + CNT_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           state, state_n;
    logic [WIDTH-1:0]     cur_min, cur_max;
    logic [SUM_WIDTH-1:0] acc_sum;
    logic [CNT_WIDTH-1:0] acc_cnt;
    logic                 ovf;

    logic                 start, accept, close;
    logic [WIDTH-1:0]     nxt_min, nxt_max;
    logic [SUM_WIDTH-1:0] nxt_sum;
    logic [CNT_WIDTH-1:0] nxt_cnt;
    logic                 nxt_ovf;

    // Sequence events. Any non-RUN state can start a new sequence, which
    // lets DONE restart back-to-back and ERROR recover on go.
    always_comb begin
        start  = (state != S_RUN) && go && !finish;
        accept = (state == S_RUN) && !go && data_valid;
        close  = (state == S_RUN) && !go && finish;
    end

    // Accumulator values after this cycle's sample; the close cycle loads
    // results from these so a sample arriving with finish is included.
    always_comb begin
        nxt_min = cur_min;
        nxt_max = cur_max;
        nxt_sum = acc_sum;
        nxt_cnt = acc_cnt;
        nxt_ovf = ovf;
        if (accept) begin
            if (data_in < cur_min) nxt_min = data_in;
            if (data_in > cur_max) nxt_max = data_in;
            // Count saturates; sum freezes with it so it can never wrap.
            if (acc_cnt != CNT_MAX) begin
                nxt_cnt = acc_cnt + CNT_WIDTH'(1);
                nxt_sum = acc_sum + SUM_WIDTH'(data_in);
            end else begin
                nxt_ovf = 1'b1;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            S_RUN: begin
                if (go)          state_n = S_ERROR;
                else if (finish) state_n = S_DONE;
            end
            S_ERROR: begin
                if (start) state_n = S_RUN;
            end
            default: begin
                if (start)       state_n = S_RUN;
                else if (finish) state_n = S_ERROR;
                else             state_n = S_IDLE;
            end
        endcase
    end

    // State, accumulators and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_min   <= '0;
            cur_max   <= '0;
            acc_sum   <= '0;
            acc_cnt   <= '0;
            ovf       <= 1'b0;
            min_out   <= '0;
            max_out   <= '0;
            range     <= '0;
            sum_out   <= '0;
            count_out <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                cur_min <= data_in;
                cur_max <= data_in;
                acc_sum <= SUM_WIDTH'(data_in);
                acc_cnt <= CNT_WIDTH'(1);
                ovf     <= 1'b0;
            end else if (accept) begin
                cur_min <= nxt_min;
                cur_max <= nxt_max;
                acc_sum <= nxt_sum;
                acc_cnt <= nxt_cnt;
                ovf     <= nxt_ovf;
            end
            if (close) begin
                min_out   <= nxt_min;
                max_out   <= nxt_max;
                range     <= nxt_max - nxt_min;
                sum_out   <= nxt_sum;
                count_out <= nxt_cnt;
                overflow  <= nxt_ovf;
            end
        end
    end

    // Status outputs decode straight from the registered state.
    always_comb begin
        busy         = (state == S_RUN);
        error        = (state == S_ERROR);
        result_valid = (state == S_DONE);
    end
endmodule

// File: tb/tb_range_stats_unit.sv
// Directed bench for range_stats_unit. Expected results are queued when a
// finish is driven and compared whenever the DUT pulses result_valid.
// A second instance with CNT_WIDTH=3 shares the stimulus for saturation.
module tb_range_stats_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic        go = 1'b0;
    logic        finish = 1'b0;

    logic [7:0]  min0, max0, rng0;
    logic [15:0] sum0;
    logic [7:0]  cnt0;
    logic        ovf0, rv0, err0, busy0;

    logic [7:0]  min1, max1, rng1;
    logic [10:0] sum1;
    logic [2:0]  cnt1;
    logic        ovf1, rv1, err1, busy1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mn; int mx; int rg; int sm; int ct; int ov;
    } exp_t;
    exp_t sb[$];

    range_stats_unit #(.WIDTH(8), .CNT_WIDTH(8)) u0 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .go(go), .finish(finish), .min_out(min0), .max_out(max0), .range(rng0),
        .sum_out(sum0), .count_out(cnt0), .overflow(ovf0), .result_valid(rv0),
        .error(err0), .busy(busy0));

    range_stats_unit #(.WIDTH(8), .CNT_WIDTH(3)) u1 (
        .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .go(go), .finish(finish), .min_out(min1), .max_out(max1), .range(rng1),
        .sum_out(sum1), .count_out(cnt1), .overflow(ovf1), .result_valid(rv1),
        .error(err1), .busy(busy1));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int mn, input int mx, input int sm, input int ct, input int ov);
        exp_t e;
        e.mn = mn; e.mx = mx; e.rg = mx - mn; e.sm = sm; e.ct = ct; e.ov = ov;
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus, then sample 1 time unit after the edge
    // and retire a scoreboard entry if the wide instance reports a result.
    task automatic step(input logic g, input logic f, input logic v, input logic [7:0] d);
        exp_t e;
        go = g; finish = f; data_valid = v; data_in = d;
        @(posedge clock);
        #1;
        if (rv0 === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_min",   32'(min0), e.mn);
                chk("sb_max",   32'(max0), e.mx);
                chk("sb_range", 32'(rng0), e.rg);
                chk("sb_sum",   32'(sum0), e.sm);
                chk("sb_count", 32'(cnt0), e.ct);
                chk("sb_ovf",   32'(ovf0), e.ov);
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_min"},   32'(min0), 0);
        chk({tag, "_max"},   32'(max0), 0);
        chk({tag, "_range"}, 32'(rng0), 0);
        chk({tag, "_sum"},   32'(sum0), 0);
        chk({tag, "_count"}, 32'(cnt0), 0);
        chk({tag, "_ovf"},   32'(ovf0), 0);
        chk({tag, "_rv"},    32'(rv0), 0);
        chk({tag, "_err"},   32'(err0), 0);
        chk({tag, "_busy"},  32'(busy0), 0);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        step(0, 0, 0, 8'd0);
        step(0, 0, 0, 8'd0);
        chk_all_zero("reset");
        reset = 1'b0;

        // Basic sequence: 20, 5, 40, 17
        step(1, 0, 0, 8'd20);
        chk("t1_busy", 32'(busy0), 1);
        step(0, 0, 1, 8'd5);
        step(0, 0, 1, 8'd40);
        step(0, 0, 1, 8'd17);
        push(5, 40, 82, 4, 0);
        step(0, 1, 0, 8'd99);
        chk("t1_rv", 32'(rv0), 1);
        chk("t1_busy_done", 32'(busy0), 0);
        step(0, 0, 0, 8'd0);
        chk("t1_rv_one_cycle", 32'(rv0), 0);
        chk("t1_hold_min", 32'(min0), 5);

        // finish in IDLE -> error level, then recovery with sample on finish
        step(0, 1, 0, 8'd0);
        chk("t2_err", 32'(err0), 1);
        step(0, 0, 1, 8'd77);
        chk("t2_err_held", 32'(err0), 1);
        step(1, 0, 0, 8'd7);
        chk("t2_err_clear", 32'(err0), 0);
        chk("t2_busy", 32'(busy0), 1);
        push(7, 9, 16, 2, 0);
        step(0, 1, 1, 8'd9);
        chk("t2_rv", 32'(rv0), 1);
        step(0, 0, 0, 8'd0);

        // go mid-RUN -> error, previous result held
        step(1, 0, 0, 8'd10);
        step(0, 0, 1, 8'd30);
        step(1, 0, 1, 8'd50);
        chk("t3_err", 32'(err0), 1);
        chk("t3_rv", 32'(rv0), 0);
        chk("t3_hold_min", 32'(min0), 7);
        chk("t3_hold_max", 32'(max0), 9);
        chk("t3_hold_range", 32'(rng0), 2);
        chk("t3_hold_sum", 32'(sum0), 16);
        chk("t3_hold_count", 32'(cnt0), 2);
        step(0, 0, 0, 8'd0);
        chk("t3_rv_still", 32'(rv0), 0);
        chk("t3_err_level", 32'(err0), 1);

        // Saturation: go(255) then 8 more valid 255 samples
        step(1, 0, 0, 8'd255);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'd255);
        push(255, 255, 2295, 9, 0);
        step(0, 1, 0, 8'd0);
        chk("t4_rv_narrow", 32'(rv1), 1);
        chk("t4_count", 32'(cnt1), 7);
        chk("t4_sum", 32'(sum1), 1785);
        chk("t4_min", 32'(min1), 255);
        chk("t4_max", 32'(max1), 255);
        chk("t4_range", 32'(rng1), 0);
        chk("t4_ovf", 32'(ovf1), 1);

        // go in the DONE cycle: back-to-back sequence
        step(1, 0, 0, 8'd3);
        chk("t5_rv_gap", 32'(rv0), 0);
        chk("t5_busy", 32'(busy0), 1);
        step(0, 0, 1, 8'd1);
        push(1, 3, 4, 2, 0);
        step(0, 1, 0, 8'd0);
        chk("t5_rv", 32'(rv0), 1);
        chk("t5_range", 32'(rng0), 2);
        step(0, 0, 0, 8'd0);

        // Reset mid-RUN (with finish also asserted) aborts silently
        step(1, 0, 0, 8'd50);
        step(0, 0, 1, 8'd60);
        reset = 1'b1;
        step(0, 1, 1, 8'd70);
        chk_all_zero("t6_reset");
        reset = 1'b0;
        step(0, 0, 0, 8'd0);
        chk("t6_rv", 32'(rv0), 0);
        step(0, 1, 0, 8'd0);
        chk("t6_err", 32'(err0), 1);
        chk("t6_min_zero", 32'(min0), 0);

        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
